// File: rtl/inv_sbox_pkg.sv
// inv_sbox_pkg: types, basis-change matrices and GF(2^4) helpers for the
// composite-field AES inverse S-box.
// GF(2^4) = GF(2)[w]/(w^4 + w + 1); GF((2^4)^2) = GF(2^4)[X]/(X^2 + X + LAMBDA).
// A composite byte {h, l} (h in bits 7:4) stands for h*X + l.
package inv_sbox_pkg;

    typedef logic [3:0] nibble_t;
    typedef logic [7:0] byte_t;
    // Bit matrix stored by column: entry [k] is the image of input bit k.
    typedef logic [7:0][7:0] bmat_t;

    // Additive constant of the inverse affine step.
    localparam byte_t AFF_C = 8'h05;

    // w^3 + w^2: trace 1, so X^2 + X + LAMBDA is irreducible over GF(2^4).
    localparam nibble_t LAMBDA = 4'b1100;

    // GF(2^8) -> composite basis with the inverse affine linear part folded in.
    // Basis: w -> 0xE1, X -> 0xA2 in the AES field.
    localparam bmat_t M_IN = {8'hD4, 8'hAD, 8'h6D, 8'h67,
                              8'h4C, 8'hDC, 8'hDA, 8'h2C};

    // Composite basis -> GF(2^8); column k is the field image of composite bit k.
    localparam bmat_t M_OUT = {8'hD9, 8'h02, 8'h1A, 8'hA2,
                               8'h0C, 8'h5C, 8'hE1, 8'h01};

    function automatic byte_t mat_vec(bmat_t m, byte_t v);
        byte_t r;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            if (v[k]) r = r ^ m[k];
        end
        return r;
    endfunction

    function automatic byte_t rotl(byte_t v, int unsigned n);
        return byte_t'((v << n) | (v >> (8 - n)));
    endfunction

    // Linear part of the forward AES affine map.
    function automatic byte_t aff_fwd_lin(byte_t v);
        return v ^ rotl(v, 1) ^ rotl(v, 2) ^ rotl(v, 3) ^ rotl(v, 4);
    endfunction

    // Ainv(a) ^ 0x05 == Ainv(a ^ A(0x05)), so the constant rides through M_IN.
    localparam byte_t IN_C = mat_vec(M_IN, aff_fwd_lin(AFF_C));

    function automatic nibble_t gf16_sq(nibble_t a);
        return {a[3], a[3] ^ a[1], a[2], a[2] ^ a[0]};
    endfunction

    function automatic nibble_t gf16_mul(nibble_t a, nibble_t b);
        nibble_t acc;
        nibble_t sh;
        acc = '0;
        sh  = a;
        for (int k = 0; k < 4; k++) begin
            if (b[k]) acc = acc ^ sh;
            sh = {sh[2:0], 1'b0} ^ (sh[3] ? 4'b0011 : 4'b0000);
        end
        return acc;
    endfunction

endpackage

// File: rtl/inv_sbox_gf16_inv.sv
// gf16_inv: combinational GF(2^4) multiplicative inverse, 0 maps to 0.
module gf16_inv
    import inv_sbox_pkg::*;
(
    input  logic [3:0] a,
    output logic [3:0] a_inv
);

    nibble_t a2;
    nibble_t a4;
    nibble_t a8;

    // a^-1 = a^14 = a^2 * a^4 * a^8; the power chain sends 0 to 0 for free
    always_comb begin
        a2    = gf16_sq(a);
        a4    = gf16_sq(a2);
        a8    = gf16_sq(a4);
        a_inv = gf16_mul(gf16_mul(a2, a4), a8);
    end

endmodule

// File: rtl/inv_sbox.sv
// inv_sbox: AES InvSubBytes via a composite-field GF((2^4)^2) inverter.
// Optional macro INV_SBOX_OUT_REG_EN adds one output register (latency 1,
// async active-low clear); without it the path is purely combinational.
module inv_sbox
    import inv_sbox_pkg::*;
(
    input  logic clk,
    input  logic i7,
    input  logic i6,
    input  logic i5,
    input  logic i4,
    input  logic i3,
    input  logic i2,
    input  logic i1,
    input  logic i0,
    output logic o7,
    output logic o6,
    output logic o5,
    output logic o4,
    output logic o3,
    output logic o2,
    output logic o1,
    output logic o0,
    input  logic rst_n
);

    byte_t   din;
    byte_t   comp;
    byte_t   res;
    byte_t   dout;
    nibble_t h;
    nibble_t l;
    nibble_t delta;
    nibble_t delta_inv;
    nibble_t h_out;
    nibble_t l_out;

    assign din = {i7, i6, i5, i4, i3, i2, i1, i0};

    // (hX + l)^-1 = (h*d)X + (h + l)*d with d = (h^2*LAMBDA + h*l + l^2)^-1
    always_comb begin
        comp  = mat_vec(M_IN, din) ^ IN_C;
        h     = comp[7:4];
        l     = comp[3:0];
        delta = gf16_mul(gf16_sq(h), LAMBDA) ^ gf16_mul(h, l) ^ gf16_sq(l);
        h_out = gf16_mul(h, delta_inv);
        l_out = gf16_mul(h ^ l, delta_inv);
        res   = mat_vec(M_OUT, {h_out, l_out});
    end

    gf16_inv u_gf16_inv (
        .a     (delta),
        .a_inv (delta_inv)
    );

`ifdef INV_SBOX_OUT_REG_EN
    byte_t res_q;

    // Output register; async clear drops any held value the moment reset asserts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q <= '0;
        end else begin
            res_q <= res;
        end
    end

    assign dout = res_q;
`else
    // Clock and reset are part of the fixed pinout but unused combinationally.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
    assign dout = res;
`endif

    assign {o7, o6, o5, o4, o3, o2, o1, o0} = dout;

endmodule

// File: tb/tb_inv_sbox.sv
// tb_inv_sbox: directed and exhaustive checks of inv_sbox against a
// brute-force GF(2^8) reference; covers the optional output register build.
module tb_inv_sbox;

    logic       clk    = 1'b0;
    logic       clk_en = 1'b0;
    logic       rst_n  = 1'b1;
    logic [7:0] din    = 8'h00;
    logic       o7, o6, o5, o4, o3, o2, o1, o0;
    logic [7:0] dout;

    int checks = 0;
    int errors = 0;

    logic [7:0] inv_tab [256];

    logic [7:0] spot_in  [6] = '{8'h63, 8'h00, 8'h7C, 8'h16, 8'hED, 8'h01};
    logic [7:0] spot_exp [6] = '{8'h00, 8'h52, 8'h01, 8'hFF, 8'h53, 8'h09};
    logic [7:0] b2b_seq  [8] = '{8'h00, 8'hFF, 8'h63, 8'h7C, 8'h16, 8'hED, 8'h01, 8'hA5};

    assign dout = {o7, o6, o5, o4, o3, o2, o1, o0};

    always #5 clk = clk_en ? ~clk : clk;

    inv_sbox dut (
        .clk   (clk),
        .i7    (din[7]),
        .i6    (din[6]),
        .i5    (din[5]),
        .i4    (din[4]),
        .i3    (din[3]),
        .i2    (din[2]),
        .i1    (din[1]),
        .i0    (din[0]),
        .o7    (o7),
        .o6    (o6),
        .o5    (o5),
        .o4    (o4),
        .o3    (o3),
        .o2    (o2),
        .o1    (o1),
        .o0    (o0),
        .rst_n (rst_n)
    );

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return 8'((v << n) | (v >> (8 - n)));
    endfunction

    function automatic logic [7:0] inv_sbox_model(input logic [7:0] x);
        return inv_tab[rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05];
    endfunction

    function automatic logic [7:0] sbox_model(input logic [7:0] x);
        logic [7:0] s;
        s = inv_tab[x];
        return s ^ rotl8(s, 1) ^ rotl8(s, 2) ^ rotl8(s, 3) ^ rotl8(s, 4) ^ 8'h63;
    endfunction

    task automatic build_model;
        inv_tab[0] = 8'h00;
        for (int a = 1; a < 256; a++) begin
            inv_tab[a] = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(a), 8'(y)) == 8'h01) inv_tab[a] = 8'(y);
            end
        end
    endtask

    // Drive one input and wait until its result is due at the output.
    task automatic apply(input logic [7:0] x);
        din = x;
`ifdef INV_SBOX_OUT_REG_EN
        @(posedge clk);
        #1;
`else
        #1;
`endif
    endtask

`ifdef INV_SBOX_OUT_REG_EN
    task automatic test_reset;
        clk_en = 1'b0;
        din    = 8'h00;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (dout !== 8'h00) begin
            errors++;
            $display("FAIL rst_async got=%02h exp=00", dout);
        end
        #5;
        checks++;
        if (dout !== 8'h00) begin
            errors++;
            $display("FAIL rst_hold got=%02h exp=00", dout);
        end
        rst_n = 1'b1;
        din   = 8'h63;
        #1;
        clk_en = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (dout !== 8'h00) begin
            errors++;
            $display("FAIL rst_first_edge got=%02h exp=00", dout);
        end
        din = 8'h7C;
        #1;
        checks++;
        if (dout !== 8'h00) begin
            errors++;
            $display("FAIL latency_hold got=%02h exp=00", dout);
        end
        @(posedge clk);
        #1;
        checks++;
        if (dout !== 8'h01) begin
            errors++;
            $display("FAIL latency_load got=%02h exp=01", dout);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (dout !== 8'h00) begin
            errors++;
            $display("FAIL rst_midstream got=%02h exp=00", dout);
        end
        #1 rst_n = 1'b1;
        #1;
        checks++;
        if (dout !== 8'h00) begin
            errors++;
            $display("FAIL rst_no_stale got=%02h exp=00", dout);
        end
        @(posedge clk);
        #1;
        checks++;
        if (dout !== 8'h01) begin
            errors++;
            $display("FAIL rst_resume got=%02h exp=01", dout);
        end
    endtask
`else
    task automatic test_reset;
        clk_en = 1'b0;
        din    = 8'h00;
        #1;
        checks++;
        if (dout !== 8'h52) begin
            errors++;
            $display("FAIL comb_pre_rst got=%02h exp=52", dout);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (dout !== 8'h52) begin
            errors++;
            $display("FAIL comb_rst_low got=%02h exp=52", dout);
        end
        #7;
        checks++;
        if (dout !== 8'h52) begin
            errors++;
            $display("FAIL comb_rst_hold got=%02h exp=52", dout);
        end
        din = 8'h7C;
        #1;
        checks++;
        if (dout !== 8'h01) begin
            errors++;
            $display("FAIL comb_track_in_rst got=%02h exp=01", dout);
        end
        din   = 8'h00;
        rst_n = 1'b1;
        #1;
        checks++;
        if (dout !== 8'h52) begin
            errors++;
            $display("FAIL comb_rst_release got=%02h exp=52", dout);
        end
        clk_en = 1'b1;
    endtask
`endif

    task automatic test_spot;
        for (int k = 0; k < 6; k++) begin
            apply(spot_in[k]);
            checks++;
            if (dout !== spot_exp[k]) begin
                errors++;
                $display("FAIL spot in=%02h got=%02h exp=%02h", spot_in[k], dout, spot_exp[k]);
            end
        end
    endtask

    task automatic test_sweep;
        logic [7:0] exp_v;
        for (int v = 0; v < 256; v++) begin
            apply(8'(v));
            exp_v = inv_sbox_model(8'(v));
            checks++;
            if (dout !== exp_v) begin
                errors++;
                $display("FAIL sweep in=%02h got=%02h exp=%02h", v[7:0], dout, exp_v);
            end
        end
    endtask

    task automatic test_round_trip;
        logic [7:0] s;
        for (int x = 0; x < 256; x++) begin
            s = sbox_model(8'(x));
            apply(s);
            checks++;
            if (dout !== 8'(x)) begin
                errors++;
                $display("FAIL round_trip x=%02h in=%02h got=%02h", x[7:0], s, dout);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] prev;
        logic [7:0] exp_v;
        apply(8'h63);
        prev = 8'h00;
        for (int k = 0; k < 8; k++) begin
            din = b2b_seq[k];
            #1;
`ifdef INV_SBOX_OUT_REG_EN
            checks++;
            if (dout !== prev) begin
                errors++;
                $display("FAIL b2b_hold in=%02h got=%02h exp=%02h", b2b_seq[k], dout, prev);
            end
            @(posedge clk);
            #1;
`endif
            exp_v = inv_sbox_model(b2b_seq[k]);
            checks++;
            if (dout !== exp_v) begin
                errors++;
                $display("FAIL b2b in=%02h got=%02h exp=%02h", b2b_seq[k], dout, exp_v);
            end
            prev = exp_v;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        build_model();
        test_reset();
        test_spot();
        test_sweep();
        test_round_trip();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
